// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer that owns the CPU program counter.
// Each instruction is one FETCH and one EXEC step, and either step stretches while its memory is busy.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         OFFSET_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    imem_busywait_i,
  input  logic                    dmem_busywait_i,
  input  logic                    jump_i,
  input  logic                    branch_i,
  input  logic                    zero_i,
  input  logic                    halt_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic [PC_WIDTH-1:0]     pc_o,
  output logic [PC_WIDTH-1:0]     pc_next_o,
  output logic                    fetch_req_o,
  output logic                    commit_o,
  output logic                    halted_o,
  output logic [PC_WIDTH-1:0]     retired_o
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] retired_q, retired_d;

  logic [PC_WIDTH-1:0] offsetExt;
  logic [PC_WIDTH-1:0] pcPlus4;
  logic [PC_WIDTH-1:0] branchTarget;
  logic [PC_WIDTH-1:0] pcNext;

  // The offset counts words, so it is sign-extended and then scaled to a byte distance.
  always_comb begin
    offsetExt    = PC_WIDTH'($signed(offset_i));
    pcPlus4      = pc_q + PC_WIDTH'(4);
    branchTarget = pcPlus4 + (offsetExt << 2);
    pcNext       = pcPlus4;
    if (jump_i || (branch_i && zero_i)) begin
      pcNext = branchTarget;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    fetch_req_o = 1'b0;
    commit_o    = 1'b0;
    halted_o    = 1'b0;
    unique case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch_req_o = 1'b1;
        if (!imem_busywait_i) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // A halting instruction still retires, but it leaves the PC pointing at itself.
        if (!dmem_busywait_i) begin
          commit_o  = 1'b1;
          retired_d = retired_q + PC_WIDTH'(1);
          if (halt_i) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pcNext;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= S_RST;
      pc_q      <= RESET_VECTOR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pcNext;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a reference model pushes the expected PC and retired count at each commit.
// Those values are popped and compared after the clock edge that retires the instruction.
module tb_pc_sequencer;

  logic        clk;
  logic        reset_ni;
  logic        imemBusy;
  logic        dmemBusy;
  logic        jump;
  logic        branch;
  logic        zero;
  logic        halt;
  logic [7:0]  offset;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        fetchReq;
  logic        commit;
  logic        halted;
  logic [31:0] retired;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycleCount  = 0;
  logic [31:0] modelPc     = 32'h0;
  logic [31:0] modelRet    = 32'h0;
  logic [31:0] expPcQ[$];
  logic [31:0] expRetQ[$];

  pc_sequencer #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(32'h0),
    .OFFSET_WIDTH(8)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .imem_busywait_i(imemBusy),
    .dmem_busywait_i(dmemBusy),
    .jump_i         (jump),
    .branch_i       (branch),
    .zero_i         (zero),
    .halt_i         (halt),
    .offset_i       (offset),
    .pc_o           (pc),
    .pc_next_o      (pcNext),
    .fetch_req_o    (fetchReq),
    .commit_o       (commit),
    .halted_o       (halted),
    .retired_o      (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Runs one instruction from FETCH through commit, with optional stalls in each phase.
  task automatic runInstr(input logic j, input logic b, input logic z, input logic h,
                          input logic [7:0] off, input int ibusy, input int dbusy);
    int          waitCycles;
    logic [31:0] ext;
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic [31:0] gotPc;
    logic [31:0] gotRet;
    waitCycles = 0;
    while (fetchReq !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    testsRun++;
    if (fetchReq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fetch_wait: fetch_req=%b required 1", fetchReq);
    end
    imemBusy = (ibusy > 0);
    for (int i = 0; i < ibusy; i++) begin
      @(negedge clk);
      testsRun++;
      if (pc !== modelPc || commit !== 1'b0 || fetchReq !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL imem_stall: pc=%h commit=%b fetch=%b required pc=%h commit=0 fetch=1",
                 pc, commit, fetchReq, modelPc);
      end
    end
    imemBusy = 1'b0;
    @(negedge clk);
    testsRun++;
    if (fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL exec_fetch: fetch_req=%b required 0", fetchReq);
    end
    jump = j; branch = b; zero = z; halt = h; offset = off;
    dmemBusy = (dbusy > 0);
    for (int i = 0; i < dbusy; i++) begin
      #1;
      testsRun++;
      if (commit !== 1'b0 || pc !== modelPc) begin
        testsFailed++;
        $display("[TB] FAIL dmem_stall: commit=%b pc=%h required commit=0 pc=%h", commit, pc, modelPc);
      end
      @(negedge clk);
    end
    dmemBusy = 1'b0;
    #1;
    ext = {{24{off[7]}}, off};
    tgt = modelPc + 32'd4 + (ext << 2);
    nxt = (j || (b && z)) ? tgt : modelPc + 32'd4;
    testsRun++;
    if (pcNext !== nxt || commit !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL commit_cycle: pc_next=%h commit=%b required pc_next=%h commit=1", pcNext, commit, nxt);
    end
    expPcQ.push_back(h ? modelPc : nxt);
    expRetQ.push_back(modelRet + 32'd1);
    modelPc  = h ? modelPc : nxt;
    modelRet = modelRet + 32'd1;
    @(negedge clk);
    gotPc  = expPcQ.pop_front();
    gotRet = expRetQ.pop_front();
    testsRun++;
    if (pc !== gotPc || retired !== gotRet || commit !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL retire: pc=%h retired=%0d commit=%b required pc=%h retired=%0d commit=0",
               pc, retired, commit, gotPc, gotRet);
    end
    jump = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0; offset = 8'h00;
  endtask

  task automatic jumpTo(input logic [31:0] target);
    logic [31:0] words;
    words = (target - modelPc - 32'd4) >> 2;
    runInstr(1'b1, 1'b0, 1'b0, 1'b0, words[7:0], 0, 0);
  endtask

  task automatic test_reset;
    reset_ni = 1'b0; imemBusy = 1'b0; dmemBusy = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0; offset = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (pc !== 32'h0 || retired !== 32'h0 || fetchReq !== 1'b0 || commit !== 1'b0 || halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: pc=%h ret=%h fetch=%b commit=%b halted=%b required all zero",
               pc, retired, fetchReq, commit, halted);
    end
    reset_ni = 1'b1;
    #1;
    testsRun++;
    if (fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_state_fetch: fetch_req=%b required 0", fetchReq);
    end
    @(negedge clk);
    testsRun++;
    if (fetchReq !== 1'b1 || pc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL first_fetch: fetch_req=%b pc=%h required 1 and 0", fetchReq, pc);
    end
    modelPc = 32'h0; modelRet = 32'h0;
  endtask

  task automatic test_plain;
    int startCycle;
    startCycle = cycleCount;
    for (int k = 0; k < 3; k++) runInstr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    testsRun++;
    if (pc !== 32'hC || retired !== 32'd3 || (cycleCount - startCycle) != 6) begin
      testsFailed++;
      $display("[TB] FAIL plain_seq: pc=%h retired=%0d cycles=%0d required pc=c retired=3 cycles=6",
               pc, retired, cycleCount - startCycle);
    end
  endtask

  task automatic test_branch;
    jumpTo(32'h20);
    runInstr(1'b0, 1'b1, 1'b1, 1'b0, 8'hFC, 0, 0);
    testsRun++;
    if (pc !== 32'h14) begin
      testsFailed++;
      $display("[TB] FAIL beq_taken: pc=%h required 14", pc);
    end
    jumpTo(32'h20);
    runInstr(1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, 0, 0);
    testsRun++;
    if (pc !== 32'h24) begin
      testsFailed++;
      $display("[TB] FAIL beq_not_taken: pc=%h required 24", pc);
    end
    jumpTo(32'h20);
    runInstr(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 0, 0);
    testsRun++;
    if (pc !== 32'h2C) begin
      testsFailed++;
      $display("[TB] FAIL jump: pc=%h required 2c", pc);
    end
    runInstr(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 0, 0);
  endtask

  task automatic test_stall;
    int startCycle;
    startCycle = cycleCount;
    runInstr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5, 3);
    testsRun++;
    if ((cycleCount - startCycle) != 10) begin
      testsFailed++;
      $display("[TB] FAIL stall_latency: cycles=%0d required 10", cycleCount - startCycle);
    end
  endtask

  task automatic test_reset_mid_stall;
    jumpTo(32'h40);
    @(negedge clk);
    dmemBusy = 1'b1;
    @(negedge clk);
    #1;
    testsRun++;
    if (pc !== 32'h40 || commit !== 1'b0 || fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_stall: pc=%h commit=%b fetch=%b required 40/0/0", pc, commit, fetchReq);
    end
    reset_ni = 1'b0;
    @(negedge clk);
    testsRun++;
    if (pc !== 32'h0 || retired !== 32'h0 || commit !== 1'b0 || halted !== 1'b0 || fetchReq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_stall: pc=%h ret=%h commit=%b halted=%b fetch=%b required all zero",
               pc, retired, commit, halted, fetchReq);
    end
    dmemBusy = 1'b0;
    reset_ni = 1'b1;
    modelPc = 32'h0; modelRet = 32'h0;
    runInstr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic test_wrap_halt;
    logic [31:0] frozenPc;
    logic [31:0] frozenRet;
    jumpTo(32'hFFFF_FFFC);
    testsRun++;
    if (pc !== 32'hFFFF_FFFC) begin
      testsFailed++;
      $display("[TB] FAIL neg_wrap: pc=%h required fffffffc", pc);
    end
    runInstr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    testsRun++;
    if (pc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL pc_wrap: pc=%h required 0", pc);
    end
    runInstr(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
    frozenPc  = modelPc;
    frozenRet = modelRet;
    for (int c = 0; c < 10; c++) begin
      imemBusy = 1'($urandom_range(1)); dmemBusy = 1'($urandom_range(1));
      jump = 1'b1; branch = 1'b1; zero = 1'b1; offset = 8'($urandom_range(255));
      #1;
      testsRun++;
      if (halted !== 1'b1 || pc !== frozenPc || retired !== frozenRet || commit !== 1'b0 || fetchReq !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL halt_frozen: halted=%b pc=%h ret=%0d commit=%b fetch=%b required 1/%h/%0d/0/0",
                 halted, pc, retired, commit, fetchReq, frozenPc, frozenRet);
      end
      @(negedge clk);
    end
    imemBusy = 1'b0; dmemBusy = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; offset = 8'h00;
    testsRun++;
    if (expPcQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", expPcQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_branch();
    test_stall();
    test_reset_mid_stall();
    test_wrap_halt();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
